riscv_trace_streamer: RTL
=========================

# riscv_trace_streamer

Commit-trace streamer that sits directly downstream of the `riscv` core's observation ports (`reg_num`/`reg_data`/`reg_write_sig`, `wr`/`rd`/`addr`/`wr_data`/`rd_data`). Each cycle with a register write or data-memory access becomes one trace event. Events are buffered in a FIFO and serialized as fixed 11-byte packets over a byte-wide valid/ready stream, which feeds a UART or a bench scoreboard. Drops on overflow are counted and made visible through a per-event sequence number.

## Interface
- `DATA_W`, 32: width of register and memory data; fixed at 32 for packet format.
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset); clears all state immediately.
- `trace_en`  in  1  1 = capture events; 0 = ignore inputs. Draining continues when 0.
- `reg_write_sig`  in  1  core register-file write strobe.
- `reg_num`  in  5  destination register.
- `reg_data`  in  DATA_W  value written.
- `wr`, `rd`  in  1 each  data-memory write / read strobes.
- `addr`  in  9  data-memory address.
- `wr_data`, `rd_data`  in  DATA_W  store data / load data, both valid in the same cycle as the strobe.
- `tr_byte`  out  8  current packet byte.
- `tr_valid`  out  1  `tr_byte` valid.
- `tr_ready`  in  1  consumer accepts byte on an edge where `tr_valid & tr_ready`.
- `fifo_level`  out  $clog2(DEPTH)+1  occupied FIFO entries. Excludes the packet being sent.
- `dropped`  out  16  events lost to overflow; saturates at 0xFFFF.

## Operation
- Event qualifiers, per cycle:
  - `reg_v = trace_en & reg_write_sig & (reg_num != 0)`. Writes to x0 are ignored.
  - `mem_op = 2'b10` if `trace_en & wr`; else `2'b01` if `trace_en & rd`; else `2'b00`. Write wins if both strobes are high.
  - An event exists if `reg_v | (mem_op != 0)`.
- Each event receives `seq`, a 7-bit counter, then `seq` increments. This happens whether the event is stored or dropped. It wraps 127 -> 0.
- Push: the event is written to the FIFO if not full, or if full and a pop occurs in the same cycle. Otherwise it is dropped and `dropped` increments (saturating).
- Packet byte order:
  - byte0 = `{reg_v, mem_op[1:0], reg_num[4:0]}`. `reg_num` is forced to 0 when `reg_v = 0`.
  - byte1 = `{seq[6:0], addr[8]}`.
  - byte2 = `addr[7:0]`.
  - bytes3-6 = `reg_data`, LSB first.
  - bytes7-10 = mem data, LSB first: `wr_data` for a write, `rd_data` for a read.
  - Unused fields (`addr`, reg data, mem data) are zero.
- Serializer FSM, with an 88-bit shift register and a 4-bit byte index:
  - IDLE: `tr_valid = 0`. If the FIFO is non-empty: pop into the shift register, set index = 0, go to SEND.
  - SEND: `tr_valid = 1`, `tr_byte` = current byte. On a handshake: shift, index++.
  - SEND, handshake at index 10, FIFO non-empty: pop the next entry and stay in SEND with index 0 (no bubble).
  - SEND, handshake at index 10, FIFO empty: go to IDLE.
- While `tr_valid & !tr_ready`, `tr_byte` is held stable. `tr_valid` never drops mid-packet.
- `trace_en` falling mid-packet does not truncate the packet.

## Timing
- Reset values: `tr_valid` = 0, `tr_byte` = 0, `fifo_level` = 0, `dropped` = 0, `seq` = 0, FSM = IDLE. Asserting `reset` mid-packet aborts it at once; the FIFO contents are discarded.
- Latency: an event sampled at edge k is in the FIFO after k. It is popped at edge k+1, and `tr_valid` = 1 with byte0 during the cycle after k+1.
- Throughput: 1 byte per cycle with `tr_ready = 1`, i.e. 11 cycles per packet. A sustained event rate above 1 per 11 cycles eventually overflows.
- Capacity: DEPTH FIFO entries plus 1 packet in flight.
- Full + pop + push in the same edge: level unchanged, no drop.
- Empty + push: the FSM is in IDLE and cannot pop the same edge; the pop occurs next edge.
- `fifo_level`, `dropped` and `tr_*` are registered outputs.

## Test plan
- **Reset.** Hold `reset` = 0 with random inputs -> all outputs 0. Release -> `tr_valid` stays 0 while there are no events.
- **Single register write.** x5 = 0xDEADBEEF, `tr_ready` = 1 -> `tr_valid` rises 2 edges later. Bytes: 85 00 00 EF BE AD DE 00 00 00 00, then IDLE.
- **Store, and x0 suppression.**
  - Store `addr` 0x1A4, data 0x00000011 as the second event -> packet 40 03 A4 00 00 00 00 11 00 00 00.
  - A simultaneous write to x0 -> byte0 unchanged.
- **Combined event.** Load `addr` 0x010, `rd_data` 0x12345678 plus write x31 = 1 -> byte0 = 0xBF, bytes7-10 = 78 56 34 12.
- **Backpressure.** Drop `tr_ready` for 5 cycles at byte 4 -> byte 4 is held and `tr_valid` stays 1. Bytes 5-10 then follow without a gap, and a queued packet starts immediately.
- **Overflow.** `DEPTH` = 4, `tr_ready` = 0, 7 consecutive events:
  - `fifo_level` = 4 and `dropped` = 2.
  - Drained seq fields = 0, 1, 2, 3, 4.
  - The next event carries seq 7.
  - An async reset mid-packet clears all outputs immediately.

Source files
------------

// File: rtl/riscv_trace_streamer.sv
// rtl/riscv_trace_streamer.sv - commit-trace event capture, event queue and 11-byte packet serializer

module trace_fifo #(
    parameter int W     = 88,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign pop_data = mem[rd_ptr];
    assign empty    = (level == '0);
    assign full     = (level == (AW+1)'(DEPTH));

    // Storage array; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

module riscv_trace_streamer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   trace_en,
    input  logic                   reg_write_sig,
    input  logic [4:0]             reg_num,
    input  logic [DATA_W-1:0]      reg_data,
    input  logic                   wr,
    input  logic                   rd,
    input  logic [8:0]             addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic [DATA_W-1:0]      rd_data,
    output logic [7:0]             tr_byte,
    output logic                   tr_valid,
    input  logic                   tr_ready,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [15:0]            dropped
);
    localparam int PKT_W = 24 + 2 * DATA_W;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t             state;
    state_t             state_nx;
    logic [PKT_W-1:0]   shreg;
    logic [3:0]         idx;
    logic [6:0]         seq;

    logic               reg_v;
    logic [1:0]         mem_op;
    logic               ev_valid;
    logic [8:0]         ev_addr;
    logic [DATA_W-1:0]  ev_reg;
    logic [DATA_W-1:0]  ev_mem;
    logic [PKT_W-1:0]   ev_pkt;

    logic               push;
    logic               pop;
    logic               load;
    logic               shift;
    logic               drop;
    logic [PKT_W-1:0]   fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;

    // Event qualification and packet assembly; byte0 sits in the low bits so it leaves first.
    always_comb begin
        reg_v = trace_en & reg_write_sig & (reg_num != 5'd0);
        if (trace_en & wr)      mem_op = 2'b10;
        else if (trace_en & rd) mem_op = 2'b01;
        else                    mem_op = 2'b00;
        ev_valid = reg_v | (mem_op != 2'b00);
        ev_addr  = (mem_op != 2'b00) ? addr : 9'd0;
        ev_reg   = reg_v ? reg_data : '0;
        if (mem_op[1])      ev_mem = wr_data;
        else if (mem_op[0]) ev_mem = rd_data;
        else                ev_mem = '0;
        ev_pkt = {ev_mem, ev_reg, ev_addr[7:0], seq, ev_addr[8],
                  reg_v, mem_op, (reg_v ? reg_num : 5'd0)};
    end

    // A full queue still accepts an event when the serializer frees a slot on the same edge.
    assign push = ev_valid & (~fifo_full | pop);
    assign drop = ev_valid & ~push;

    trace_fifo #(
        .W     (PKT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (ev_pkt),
        .pop       (pop),
        .pop_data  (fifo_rdata),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Serializer next-state and datapath controls; last-byte pop chains packets with no bubble.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        load     = 1'b0;
        shift    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    load     = 1'b1;
                    state_nx = S_SEND;
                end
            end
            S_SEND: begin
                if (tr_ready) begin
                    if (idx == 4'd10 && !fifo_empty) begin
                        pop  = 1'b1;
                        load = 1'b1;
                    end else begin
                        shift = 1'b1;
                        if (idx == 4'd10) state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Serializer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Shift register and byte index; shifting in zeros leaves tr_byte at 0 once idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
            idx   <= 4'd0;
        end else if (load) begin
            shreg <= fifo_rdata;
            idx   <= 4'd0;
        end else if (shift) begin
            shreg <= {8'h00, shreg[PKT_W-1:8]};
            idx   <= idx + 4'd1;
        end
    end

    // Sequence numbers advance for stored and dropped events alike; drop count saturates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seq     <= 7'd0;
            dropped <= 16'd0;
        end else begin
            if (ev_valid) seq <= seq + 7'd1;
            if (drop && dropped != 16'hFFFF) dropped <= dropped + 16'd1;
        end
    end

    assign tr_valid = (state == S_SEND);
    assign tr_byte  = shreg[7:0];
endmodule
